// File: rtl/alu_vec_pkg.sv
// Shared types and helpers for the pipelined vector ALU.
package alu_vec_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_MUL = 3'b010,
      OP_SRA = 3'b011,
      OP_SRL = 3'b100,
      OP_SLL = 3'b101,
      OP_AND = 3'b110,
      OP_OR  = 3'b111
   } op_e;

   localparam int ELEMENT_DEF = 16;
   localparam int SHW         = $clog2(ELEMENT_DEF);

   // Clamp a signed value into the signed range of a width-bit element.
   // Wide enough for a full 2*ELEMENT product as long as ELEMENT <= 32.
   function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] value,
                                                    input int width);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      if (value > hi)
         return hi;
      else if (value < lo)
         return lo;
      else
         return value;
   endfunction

endpackage

// File: rtl/alu_vec_lane.sv
// Combinational single-lane element datapath.
// A disabled lane passes operand A through untouched.
module alu_vec_lane
   import alu_vec_pkg::*;
#(
   parameter int ELEMENT = 16
) (
   input  op_e                op,
   input  logic               sat,
   input  logic               en,
   input  logic [ELEMENT-1:0] a,
   input  logic [ELEMENT-1:0] b,
   output logic [ELEMENT-1:0] r,
   output logic               z
);

   localparam int SHW_L = $clog2(ELEMENT);

   logic signed [ELEMENT:0]     sum_s;
   logic signed [ELEMENT:0]     dif_s;
   logic signed [2*ELEMENT-1:0] a_x;
   logic signed [2*ELEMENT-1:0] b_x;
   logic signed [2*ELEMENT-1:0] prod_s;
   logic signed [ELEMENT-1:0]   sra_v;
   logic [SHW_L-1:0]            sh;
   logic                        big;
   logic signed [63:0]          clamp_in;
   logic signed [63:0]          clamp_out;
   logic [ELEMENT-1:0]          res;

   // One extra bit on add/sub makes signed overflow visible to the clamp.
   assign sum_s  = $signed({a[ELEMENT-1], a}) + $signed({b[ELEMENT-1], b});
   assign dif_s  = $signed({a[ELEMENT-1], a}) - $signed({b[ELEMENT-1], b});
   assign a_x    = $signed({{ELEMENT{a[ELEMENT-1]}}, a});
   assign b_x    = $signed({{ELEMENT{b[ELEMENT-1]}}, b});
   assign prod_s = a_x * b_x;

   // Any set bit above the shift field means the amount is >= ELEMENT.
   assign sh    = b[SHW_L-1:0];
   assign big   = |b[ELEMENT-1:SHW_L];
   assign sra_v = $signed(a) >>> sh;

   // Select the clamp source, then the per-op result, then apply the lane enable.
   always_comb begin
      case (op)
         OP_SUB:  clamp_in = 64'(dif_s);
         OP_MUL:  clamp_in = 64'(prod_s);
         default: clamp_in = 64'(sum_s);
      endcase
      clamp_out = sat_clamp(clamp_in, ELEMENT);

      res = a;
      case (op)
         OP_ADD:  res = sat ? clamp_out[ELEMENT-1:0] : sum_s[ELEMENT-1:0];
         OP_SUB:  res = sat ? clamp_out[ELEMENT-1:0] : dif_s[ELEMENT-1:0];
         OP_MUL:  res = sat ? clamp_out[ELEMENT-1:0] : prod_s[ELEMENT-1:0];
         OP_SRA:  res = big ? {ELEMENT{a[ELEMENT-1]}} : sra_v;
         OP_SRL:  res = big ? '0 : (a >> sh);
         OP_SLL:  res = big ? '0 : (a << sh);
         OP_AND:  res = a & b;
         OP_OR:   res = a | b;
         default: res = a;
      endcase

      r = en ? res : a;
      z = (r == '0);
   end

endmodule

// File: rtl/alu_vec_pipe.sv
// Two-stage pipelined vector ALU with valid/ready on both sides.
// S1 holds the operands, S2 holds the lane results and zero flags.
module alu_vec_pipe
   import alu_vec_pkg::*;
#(
   parameter int ELEMENT = 16,
   parameter int LANES   = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2:0]               op,
   input  logic                     sat,
   input  logic [LANES-1:0]         mask,
   input  logic [LANES*ELEMENT-1:0] vec_a,
   input  logic [LANES*ELEMENT-1:0] vec_b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LANES*ELEMENT-1:0] vec_r,
   output logic [LANES-1:0]         zero
);

   logic                     s1_v;
   op_e                      s1_op;
   logic                     s1_sat;
   logic [LANES-1:0]         s1_mask;
   logic [LANES*ELEMENT-1:0] s1_a;
   logic [LANES*ELEMENT-1:0] s1_b;
   logic                     s2_v;
   logic                     adv1;
   logic                     adv2;
   logic [LANES*ELEMENT-1:0] lane_r;
   logic [LANES-1:0]         lane_z;

   // A stage may load when it is empty or its contents move on this cycle.
   assign adv2      = !s2_v || out_ready;
   assign adv1      = !s1_v || adv2;
   assign in_ready  = adv1;
   assign out_valid = s2_v;

   // Operand stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v    <= 1'b0;
         s1_op   <= OP_ADD;
         s1_sat  <= 1'b0;
         s1_mask <= '0;
         s1_a    <= '0;
         s1_b    <= '0;
      end else if (adv1) begin
         s1_v <= in_valid;
         if (in_valid) begin
            s1_op   <= op_e'(op);
            s1_sat  <= sat;
            s1_mask <= mask;
            s1_a    <= vec_a;
            s1_b    <= vec_b;
         end
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      alu_vec_lane #(
         .ELEMENT (ELEMENT)
      ) u_lane (
         .op  (s1_op),
         .sat (s1_sat),
         .en  (s1_mask[i]),
         .a   (s1_a[i*ELEMENT +: ELEMENT]),
         .b   (s1_b[i*ELEMENT +: ELEMENT]),
         .r   (lane_r[i*ELEMENT +: ELEMENT]),
         .z   (lane_z[i])
      );
   end

   // Result stage; holds steady while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_v  <= 1'b0;
         vec_r <= '0;
         zero  <= '0;
      end else if (adv2) begin
         s2_v <= s1_v;
         if (s1_v) begin
            vec_r <= lane_r;
            zero  <= lane_z;
         end
      end
   end

endmodule

// File: tb/tb_alu_vec_pipe.sv
// Directed testbench for alu_vec_pipe (ELEMENT=16, LANES=4).
module tb_alu_vec_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  op;
   logic        sat;
   logic [3:0]  mask;
   logic [63:0] vec_a;
   logic [63:0] vec_b;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] vec_r;
   logic [3:0]  zero;

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic        sat;
      logic [3:0]  mask;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] r;
      logic [3:0]  z;
   } vec_t;

   alu_vec_pipe #(.ELEMENT(16), .LANES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .sat       (sat),
      .mask      (mask),
      .vec_a     (vec_a),
      .vec_b     (vec_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .vec_r     (vec_r),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   // Sends one beat with out_ready high and waits (bounded) for its result.
   // lat counts clock edges from the accepting edge onward; -1 on timeout.
   task automatic run_beat(input vec_t v, output logic [63:0] r, output logic [3:0] z,
                           output int lat);
      out_ready = 1'b1;
      op        = v.op;
      sat       = v.sat;
      mask      = v.mask;
      vec_a     = v.a;
      vec_b     = v.b;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat      = 1;
      while (!out_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      r = vec_r;
      z = zero;
      if (!out_valid) lat = -1;
   endtask

   task automatic check_table(input vec_t t[$]);
      logic [63:0] r;
      logic [3:0]  z;
      int          lat;
      foreach (t[k]) begin
         run_beat(t[k], r, z, lat);
         tests_run++;
         if (lat !== 2) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d edges, expected 2", t[k].name, lat);
         end
         tests_run++;
         if (r !== t[k].r) begin
            tests_failed++;
            $display("FAIL %s vec_r: got %h expected %h", t[k].name, r, t[k].r);
         end
         tests_run++;
         if (z !== t[k].z) begin
            tests_failed++;
            $display("FAIL %s zero: got %b expected %b", t[k].name, z, t[k].z);
         end
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      op = 3'd0; sat = 1'b0; mask = 4'hF; vec_a = '0; vec_b = '0;
      #1 rst_n = 1'b0;
      #2;
      tests_run++;
      if (out_valid !== 1'b0 || vec_r !== 64'h0 || zero !== 4'h0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got v=%b r=%h z=%b expected 0/0/0", out_valid, vec_r, zero);
      end
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      end
   endtask

   task automatic test_add();
      vec_t t[$];
      t.push_back('{"add_wrap", 3'd0, 1'b0, 4'hF, {16'd5, 16'hFFFF, 16'h7FFF, 16'd1},
                    {16'hFFFB, 16'd1, 16'd1, 16'd2}, {16'h0, 16'h0, 16'h8000, 16'd3}, 4'b1100});
      t.push_back('{"add_sat", 3'd0, 1'b1, 4'hF, {16'd5, 16'hFFFF, 16'h7FFF, 16'd1},
                    {16'hFFFB, 16'd1, 16'd1, 16'd2}, {16'h0, 16'h0, 16'h7FFF, 16'd3}, 4'b1100});
      check_table(t);
   endtask

   task automatic test_sub();
      vec_t t[$];
      t.push_back('{"sub_sat", 3'd1, 1'b1, 4'hF, {16'h0, 16'h7FFF, 16'd5, 16'h8000},
                    {16'h0, 16'hFFFF, 16'd7, 16'd1}, {16'h0, 16'h7FFF, 16'hFFFE, 16'h8000}, 4'b1000});
      t.push_back('{"sub_wrap", 3'd1, 1'b0, 4'hF, {16'h0, 16'h7FFF, 16'd5, 16'h8000},
                    {16'h0, 16'hFFFF, 16'd7, 16'd1}, {16'h0, 16'h8000, 16'hFFFE, 16'h7FFF}, 4'b1000});
      check_table(t);
   endtask

   task automatic test_mul();
      vec_t t[$];
      t.push_back('{"mul_sat", 3'd2, 1'b1, 4'hF, {16'hFFFF, 16'h0003, 16'hFF00, 16'h0100},
                    {16'hFFFF, 16'hFFFE, 16'h0100, 16'h0100}, {16'h0001, 16'hFFFA, 16'h8000, 16'h7FFF}, 4'b0000});
      t.push_back('{"mul_wrap", 3'd2, 1'b0, 4'hF, {16'hFFFF, 16'h0003, 16'hFF00, 16'h0100},
                    {16'hFFFF, 16'hFFFE, 16'h0100, 16'h0100}, {16'h0001, 16'hFFFA, 16'h0000, 16'h0000}, 4'b0011});
      check_table(t);
   endtask

   task automatic test_shift();
      vec_t t[$];
      t.push_back('{"sra", 3'd3, 1'b1, 4'hF, {4{16'h8001}},
                    {16'd15, 16'd0, 16'd20, 16'd1}, {16'hFFFF, 16'h8001, 16'hFFFF, 16'hC000}, 4'b0000});
      t.push_back('{"srl", 3'd4, 1'b0, 4'hF, {4{16'h8001}},
                    {16'd15, 16'd0, 16'd1, 16'd16}, {16'h0001, 16'h8001, 16'h4000, 16'h0000}, 4'b0001});
      t.push_back('{"sll", 3'd5, 1'b0, 4'hF, {4{16'h8001}},
                    {16'd0, 16'd1, 16'd16, 16'd15}, {16'h8001, 16'h0002, 16'h0000, 16'h8000}, 4'b0010});
      check_table(t);
   endtask

   task automatic test_logic_mask();
      vec_t t[$];
      t.push_back('{"and_mask", 3'd6, 1'b1, 4'b0101, {4{16'hFFFF}},
                    {4{16'h00F0}}, {16'hFFFF, 16'h00F0, 16'hFFFF, 16'h00F0}, 4'b0000});
      t.push_back('{"or", 3'd7, 1'b0, 4'hF, {16'h0, 16'h1234, 16'h0, 16'h00F0},
                    {16'h0, 16'h0, 16'h0, 16'h0F00}, {16'h0, 16'h1234, 16'h0, 16'h0FF0}, 4'b1010});
      t.push_back('{"mask_none", 3'd0, 1'b0, 4'h0, {16'd2, 16'd0, 16'd1, 16'd0},
                    {4{16'd5}}, {16'd2, 16'd0, 16'd1, 16'd0}, 4'b0101});
      check_table(t);
   endtask

   function automatic logic [63:0] b2b_a(int k);
      logic [63:0] v;
      for (int i = 0; i < 4; i++) v[i*16 +: 16] = 16'(256 * i + k);
      return v;
   endfunction

   function automatic logic [63:0] b2b_r(int k);
      logic [63:0] v;
      for (int i = 0; i < 4; i++) v[i*16 +: 16] = 16'(256 * i + k + 16);
      return v;
   endfunction

   task automatic test_back_to_back();
      int   sent = 0;
      int   recv = 0;
      logic fire_in;
      logic stall;
      repeat (2) @(posedge clk);
      #1;
      op = 3'd0; sat = 1'b0; mask = 4'hF; vec_b = {4{16'h0010}};
      for (int c = 0; c < 40 && recv < 8; c++) begin
         stall     = (c >= 3 && c <= 6);
         out_ready = !stall;
         in_valid  = (sent < 8);
         if (sent < 8) vec_a = b2b_a(sent);
         #1;
         if (sent < 8) begin
            tests_run++;
            if (in_ready !== !stall) begin
               tests_failed++;
               $display("FAIL b2b_in_ready c%0d: got %b expected %b", c, in_ready, !stall);
            end
         end
         if (stall) begin
            tests_run++;
            if (out_valid !== 1'b1 || vec_r !== b2b_r(1)) begin
               tests_failed++;
               $display("FAIL b2b_hold c%0d: got v=%b r=%h expected 1/%h", c, out_valid, vec_r, b2b_r(1));
            end
         end else if (c >= 2 && recv < 8) begin
            tests_run++;
            if (out_valid !== 1'b1) begin
               tests_failed++;
               $display("FAIL b2b_throughput c%0d: got out_valid=%b expected 1", c, out_valid);
            end
         end
         if (out_valid && out_ready) begin
            tests_run++;
            if (vec_r !== b2b_r(recv) || zero !== 4'h0) begin
               tests_failed++;
               $display("FAIL b2b_result %0d: got %h/%b expected %h/0000", recv, vec_r, zero, b2b_r(recv));
            end
            recv++;
         end
         fire_in = in_valid && in_ready;
         @(posedge clk); #1;
         if (fire_in) sent++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tests_run++;
      if (recv !== 8 || sent !== 8) begin
         tests_failed++;
         $display("FAIL b2b_count: got sent=%0d recv=%0d expected 8/8", sent, recv);
      end
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_no_extra: got out_valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_reset_mid();
      logic stale = 1'b0;
      out_ready = 1'b1;
      op = 3'd0; sat = 1'b0; mask = 4'hF; vec_b = {4{16'h0001}};
      vec_a    = {4{16'h1111}};
      in_valid = 1'b1;
      @(posedge clk); #1;
      vec_a = {4{16'h2222}};
      @(posedge clk); #1;
      in_valid = 1'b0;
      tests_run++;
      if (out_valid !== 1'b1 || vec_r !== {4{16'h1112}}) begin
         tests_failed++;
         $display("FAIL mid_inflight: got v=%b r=%h expected 1/%h", out_valid, vec_r, {4{16'h1112}});
      end
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || vec_r !== 64'h0 || zero !== 4'h0) begin
         tests_failed++;
         $display("FAIL mid_async_clear: got v=%b r=%h z=%b expected 0/0/0", out_valid, vec_r, zero);
      end
      @(posedge clk);
      #2 rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         if (out_valid) stale = 1'b1;
      end
      tests_run++;
      if (stale !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_stale: got stale beat=%b expected 0", stale);
      end
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL mid_in_ready: got %b expected 1", in_ready);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_mul();
      test_shift();
      test_logic_mask();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
